// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master bridge: FSM state encoding,
// default bus widths and packed command/response records.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  typedef struct packed {
    logic                  write;
    logic [APB_DATA_W-1:0] rdata;
  } apb_rsp_t;

endpackage

// File: rtl/apb_if.sv
// Signal bundle between the system-side command/response streams, the
// bridge, and the APB bus. The master modport is the bridge's view; the
// slave modport is the view of everything around it.
interface apb_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  // command stream
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // response stream
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;

  // APB bus
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_write, rsp_rdata,
    input  rsp_ready,
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_write, rsp_rdata,
    output rsp_ready,
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata
  );

endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command stream into fixed two-cycle
// SETUP/ACCESS transfers and returns completions through a one-entry
// response slot. A new command may be accepted during ACCESS, so transfers
// run back to back whenever the response slot can take the result.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) (
  input logic   pclk,
  input logic   preset,
  apb_if.master bus
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              slot_free;
  logic              req_ready;
  logic              accept;

  // Acceptance: only in IDLE or ACCESS, and only if the slot can absorb a result.
  always_comb begin
    slot_free = !rsp_valid_q || bus.rsp_ready;
    req_ready = ((state_q == IDLE) || (state_q == ACCESS)) && slot_free;
    accept    = req_ready && bus.req_valid;
  end

  // Next state and APB output registers; address/direction/data hold outside of a capture.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (accept) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      paddr_d  = bus.req_addr;
      pwrite_d = bus.req_write;
      pwdata_d = bus.req_write ? bus.req_wdata : '0;
    end

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  // Response slot: drained by the consumer, loaded on the closing edge of ACCESS.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;

    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (state_q == ACCESS) begin
      rsp_valid_d = 1'b1;
      rsp_write_d = pwrite_q;
      rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: reset values, single write and read,
// back-to-back writes, response-slot stall, and reset during ACCESS.
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic pclk;
  logic preset;
  int   checkCount = 0;
  int   errorCount = 0;
  int   rspSeen;

  apb_req_t writes [4];
  apb_req_t idleReq;

  apb_if #(.ADDR_W(APB_ADDR_W), .DATA_W(APB_DATA_W)) bus ();

  apb_master_bridge #(
    .ADDR_W(APB_ADDR_W),
    .DATA_W(APB_DATA_W)
  ) dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  // free-running bus clock, 10 time units per cycle
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input apb_req_t req);
    bus.req_valid = valid;
    bus.req_write = req.write;
    bus.req_addr  = req.addr;
    bus.req_wdata = req.wdata;
  endtask

  task automatic nextCycle;
    @(negedge pclk);
  endtask

  // directed sequence; all observations happen on the falling edge
  initial begin
    idleReq = '0;
    for (int i = 0; i < 4; i++) begin
      writes[i] = '{write: 1'b1, addr: 32'(4 * i), wdata: 32'hA000_0000 + 32'(i)};
    end

    preset        = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.prdata    = '0;
    applyStimulus(1'b0, idleReq);
    repeat (3) nextCycle;
    preset = 1'b0;

    // reset state
    checkOutput("rst_psel",      32'(bus.psel),      32'd0);
    checkOutput("rst_penable",   32'(bus.penable),   32'd0);
    checkOutput("rst_pwrite",    32'(bus.pwrite),    32'd0);
    checkOutput("rst_paddr",     bus.paddr,          32'd0);
    checkOutput("rst_pwdata",    bus.pwdata,         32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rsp_write", 32'(bus.rsp_write), 32'd0);
    checkOutput("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // single write
    applyStimulus(1'b1, '{write: 1'b1, addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF});
    checkOutput("wr_req_ready", 32'(bus.req_ready), 32'd1);
    nextCycle;
    checkOutput("wr_setup_psel",    32'(bus.psel),      32'd1);
    checkOutput("wr_setup_penable", 32'(bus.penable),   32'd0);
    checkOutput("wr_setup_pwrite",  32'(bus.pwrite),    32'd1);
    checkOutput("wr_setup_paddr",   bus.paddr,          32'h10);
    checkOutput("wr_setup_pwdata",  bus.pwdata,         32'hDEAD_BEEF);
    checkOutput("wr_setup_rsp",     32'(bus.rsp_valid), 32'd0);
    checkOutput("wr_setup_ready",   32'(bus.req_ready), 32'd0);
    applyStimulus(1'b0, idleReq);
    nextCycle;
    checkOutput("wr_access_psel",    32'(bus.psel),      32'd1);
    checkOutput("wr_access_penable", 32'(bus.penable),   32'd1);
    checkOutput("wr_access_paddr",   bus.paddr,          32'h10);
    checkOutput("wr_access_pwdata",  bus.pwdata,         32'hDEAD_BEEF);
    checkOutput("wr_access_rsp",     32'(bus.rsp_valid), 32'd0);
    nextCycle;
    checkOutput("wr_rsp_valid",   32'(bus.rsp_valid), 32'd1);
    checkOutput("wr_rsp_write",   32'(bus.rsp_write), 32'd1);
    checkOutput("wr_rsp_rdata",   bus.rsp_rdata,      32'd0);
    checkOutput("wr_idle_psel",   32'(bus.psel),      32'd0);
    checkOutput("wr_idle_pen",    32'(bus.penable),   32'd0);
    checkOutput("wr_idle_paddr",  bus.paddr,          32'h10);
    checkOutput("wr_idle_pwdata", bus.pwdata,         32'hDEAD_BEEF);
    nextCycle;
    checkOutput("wr_rsp_drained", 32'(bus.rsp_valid), 32'd0);

    // single read
    applyStimulus(1'b1, '{write: 1'b0, addr: 32'h0000_0024, wdata: 32'hFFFF_FFFF});
    bus.prdata = 32'h1234_5678;
    checkOutput("rd_req_ready", 32'(bus.req_ready), 32'd1);
    nextCycle;
    checkOutput("rd_setup_psel",    32'(bus.psel),    32'd1);
    checkOutput("rd_setup_penable", 32'(bus.penable), 32'd0);
    checkOutput("rd_setup_pwrite",  32'(bus.pwrite),  32'd0);
    checkOutput("rd_setup_paddr",   bus.paddr,        32'h24);
    checkOutput("rd_setup_pwdata",  bus.pwdata,       32'd0);
    applyStimulus(1'b0, idleReq);
    nextCycle;
    checkOutput("rd_access_penable", 32'(bus.penable), 32'd1);
    checkOutput("rd_access_pwdata",  bus.pwdata,       32'd0);
    checkOutput("rd_access_paddr",   bus.paddr,        32'h24);
    nextCycle;
    bus.prdata = 32'd0;
    checkOutput("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("rd_rsp_write", 32'(bus.rsp_write), 32'd0);
    checkOutput("rd_rsp_rdata", bus.rsp_rdata,      32'h1234_5678);
    nextCycle;
    checkOutput("rd_rsp_drained", 32'(bus.rsp_valid), 32'd0);

    // four back-to-back writes with the consumer always ready
    rspSeen = 0;
    for (int k = 0; k < 10; k++) begin
      if (k >= 1 && k <= 8) begin
        checkOutput($sformatf("b2b_psel_%0d", k),    32'(bus.psel),    32'd1);
        checkOutput($sformatf("b2b_penable_%0d", k), 32'(bus.penable), 32'((k % 2) == 0));
        checkOutput($sformatf("b2b_paddr_%0d", k),   bus.paddr,        32'(4 * ((k - 1) / 2)));
        checkOutput($sformatf("b2b_pwdata_%0d", k),  bus.pwdata,       32'hA000_0000 + 32'((k - 1) / 2));
      end else begin
        checkOutput($sformatf("b2b_psel_%0d", k), 32'(bus.psel), 32'd0);
      end
      if (k >= 3 && (k % 2) == 1) begin
        checkOutput($sformatf("b2b_rsp_valid_%0d", k), 32'(bus.rsp_valid), 32'd1);
        checkOutput($sformatf("b2b_rsp_write_%0d", k), 32'(bus.rsp_write), 32'd1);
        if (bus.rsp_valid && bus.rsp_write) rspSeen++;
      end else begin
        checkOutput($sformatf("b2b_rsp_valid_%0d", k), 32'(bus.rsp_valid), 32'd0);
      end
      if ((k % 2) == 0 && k < 8) begin
        applyStimulus(1'b1, writes[k / 2]);
        checkOutput($sformatf("b2b_req_ready_%0d", k), 32'(bus.req_ready), 32'd1);
      end else begin
        applyStimulus(1'b0, idleReq);
      end
      nextCycle;
    end
    checkOutput("b2b_rsp_count", 32'(rspSeen), 32'd4);
    checkOutput("b2b_final_rsp", 32'(bus.rsp_valid), 32'd0);

    // response slot stall: first read completes, consumer not ready
    bus.rsp_ready = 1'b0;
    bus.prdata    = 32'hAAAA_5555;
    applyStimulus(1'b1, '{write: 1'b0, addr: 32'h0000_0030, wdata: 32'd0});
    checkOutput("stall_first_ready", 32'(bus.req_ready), 32'd1);
    nextCycle;
    applyStimulus(1'b0, idleReq);
    nextCycle;
    nextCycle;
    checkOutput("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("stall_rsp_rdata", bus.rsp_rdata,      32'hAAAA_5555);
    bus.prdata = 32'hBBBB_0000;
    applyStimulus(1'b1, '{write: 1'b0, addr: 32'h0000_0034, wdata: 32'd0});
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("stall_req_ready_%0d", i), 32'(bus.req_ready), 32'd0);
      checkOutput($sformatf("stall_psel_%0d", i),      32'(bus.psel),      32'd0);
      checkOutput($sformatf("stall_hold_valid_%0d", i), 32'(bus.rsp_valid), 32'd1);
      checkOutput($sformatf("stall_hold_write_%0d", i), 32'(bus.rsp_write), 32'd0);
      checkOutput($sformatf("stall_hold_rdata_%0d", i), bus.rsp_rdata,      32'hAAAA_5555);
      nextCycle;
    end
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("stall_release_ready", 32'(bus.req_ready), 32'd1);
    nextCycle;
    checkOutput("stall2_setup_psel",    32'(bus.psel),      32'd1);
    checkOutput("stall2_setup_penable", 32'(bus.penable),   32'd0);
    checkOutput("stall2_setup_paddr",   bus.paddr,          32'h34);
    checkOutput("stall2_rsp_drained",   32'(bus.rsp_valid), 32'd0);
    applyStimulus(1'b0, idleReq);
    nextCycle;
    checkOutput("stall2_access_penable", 32'(bus.penable), 32'd1);
    nextCycle;
    checkOutput("stall2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("stall2_rsp_rdata", bus.rsp_rdata,      32'hBBBB_0000);
    nextCycle;
    checkOutput("stall2_drained", 32'(bus.rsp_valid), 32'd0);

    // reset asserted during ACCESS of a read
    bus.prdata = 32'hCAFE_0001;
    applyStimulus(1'b1, '{write: 1'b0, addr: 32'h0000_0040, wdata: 32'd0});
    nextCycle;
    applyStimulus(1'b0, idleReq);
    nextCycle;
    checkOutput("rst_acc_penable", 32'(bus.penable), 32'd1);
    checkOutput("rst_acc_paddr",   bus.paddr,        32'h40);
    preset = 1'b1;
    nextCycle;
    preset = 1'b0;
    checkOutput("rst_acc_psel",      32'(bus.psel),      32'd0);
    checkOutput("rst_acc_pen_low",   32'(bus.penable),   32'd0);
    checkOutput("rst_acc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_acc_paddr0",    bus.paddr,          32'd0);
    checkOutput("rst_acc_rdata0",    bus.rsp_rdata,      32'd0);
    for (int i = 0; i < 4; i++) begin
      nextCycle;
      checkOutput($sformatf("rst_acc_no_rsp_%0d", i),  32'(bus.rsp_valid), 32'd0);
      checkOutput($sformatf("rst_acc_no_psel_%0d", i), 32'(bus.psel),      32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
